clock_edge_monitor: RTL
=======================

CLOCK_EDGE_MONITOR -- requirements
Module: clock_edge_monitor

Interface
REQ-001 Parameter par_clk_divisor, default 1000: expected i_clk_div period in i_clk_mhz cycles; even; range 4..32768.
REQ-002 Parameter par_tolerance, default 2: allowed absolute period deviation in i_clk_mhz cycles.
REQ-003 Parameter par_lock_count, default 4: consecutive in-tolerance periods required for lock; range 1..15.
REQ-004 The module SHALL have one clock; reset is asynchronous and active-high.
REQ-005 i_clk_mhz  in  1  source clock; sole clock of the block.
REQ-006 i_rst_mhz  in  1  asynchronous active-high reset.
REQ-007 i_clk_div  in  1  divided clock from the far end; asynchronous to i_clk_mhz; used as data only.
REQ-008 i_rst_div  in  1  divided-domain reset from the far end; asynchronous.
REQ-009 o_rise_ce  out  1  one-cycle pulse per detected i_clk_div rising edge.
REQ-010 o_fall_ce  out  1  one-cycle pulse per detected i_clk_div falling edge.
REQ-011 o_rst_sync  out  1  i_rst_div synchronized to i_clk_mhz, ORed with i_rst_mhz.
REQ-012 o_locked  out  1  high while state is LOCKED.
REQ-013 o_fault  out  1  sticky period or timeout fault.
REQ-014 o_period  out  16  last measured rise-to-rise period in i_clk_mhz cycles.

Function
REQ-015 i_clk_div and i_rst_div SHALL each pass through a 2-flop synchronizer, followed by one history flop for edge detection.
REQ-016 o_rise_ce SHALL be high for exactly one cycle, 3 i_clk_mhz edges after the first edge that samples i_clk_div high; o_fall_ce is symmetric for the low transition.
REQ-017 A free-running 16-bit period counter SHALL reset to 1 on each rise_ce cycle, otherwise increment, saturating at 65535.
REQ-018 Each rise_ce SHALL be in tolerance when |count - par_clk_divisor| <= par_tolerance, evaluated at 17-bit signed width.
REQ-019 FSM states: IDLE, ACQUIRE, LOCKED, FAULT.
REQ-020 IDLE -> ACQUIRE on the first rise_ce; no period is evaluated on that edge.
REQ-021 In ACQUIRE, an in-tolerance rise_ce SHALL increment a 4-bit good counter; an out-of-tolerance rise_ce SHALL clear it; reaching par_lock_count SHALL move the FSM to LOCKED.
REQ-022 In LOCKED, an out-of-tolerance rise_ce SHALL move the FSM to FAULT and set o_fault.
REQ-023 In ACQUIRE or LOCKED, a count exceeding 2*par_clk_divisor without rise_ce (timeout) SHALL move the FSM to FAULT and set o_fault.
REQ-024 In FAULT, the next rise_ce SHALL move the FSM to ACQUIRE with the good counter cleared; o_fault SHALL remain set.
REQ-025 While synchronized i_rst_div is high:
  - FSM is forced to IDLE.
  - Good counter and o_fault are cleared.
  - Edge pulses continue.
REQ-026 If a rise_ce and a timeout occur in the same cycle, rise_ce SHALL take priority.
REQ-027 Synchronized i_rst_div high in the same cycle as any transition SHALL take priority.

Reset
REQ-028 On i_rst_mhz, all outputs SHALL be driven as follows:
  - o_rise_ce=0, o_fall_ce=0, o_locked=0, o_fault=0, o_period=0.
  - o_rst_sync=1.
  - Synchronizer flops = 0; FSM = IDLE; counters = 0.
REQ-029 Assertion of o_rst_sync SHALL be asynchronous with i_rst_mhz; deassertion SHALL be synchronous, 2 cycles after both i_rst_mhz and synchronized i_rst_div are low.

Configuration
REQ-030 With macro CLOCK_EDGE_MONITOR_PERIOD_OUT_EN defined, o_period SHALL load the measured period on every evaluated rise_ce; without it, o_period SHALL be tied to 0 and the 16-bit output register SHALL not be built (FSM behaviour unchanged).

Verification
Defaults for all scenarios: par_clk_divisor=10, par_tolerance=1, par_lock_count=4.
REQ-031 Steady i_clk_div of 10 cycles from reset release -> o_locked rises at the 5th rise_ce; o_rise_ce and o_fall_ce alternate with 5-cycle spacing; o_period=10 (macro on).
REQ-032 Locked, then one i_clk_div period of 13 cycles -> at that rise_ce: FSM=FAULT, o_fault=1, o_locked=0; next rise_ce -> ACQUIRE; o_fault stays 1.
REQ-033 Locked, then i_clk_div held low -> fault asserted at count 21 (timeout); no rise_ce pulses.
REQ-034 Periods 9,11,9,11 -> lock achieved; a single 12 in ACQUIRE -> good counter restarts; 4 further good periods are required before lock.
REQ-035 i_rst_div pulsed high 3 cycles while LOCKED with fault set -> o_rst_sync high 3 cycles (2-cycle latency); FSM=IDLE; o_fault=0; o_locked=0.
REQ-036 i_rst_mhz asserted mid-period -> all outputs at reset values in the same cycle, with o_rst_sync=1 immediately; macro off -> o_period=0 throughout.

Source files
------------

// File: rtl/clock_edge_monitor_if.sv
// Divided-clock monitor bundle: far-end clock/reset in, edge/lock status out.
// master drives the far-end signals, slave is the monitor.
interface clock_edge_monitor_if;
  logic        i_clk_div;
  logic        i_rst_div;
  logic        o_rise_ce;
  logic        o_fall_ce;
  logic        o_rst_sync;
  logic        o_locked;
  logic        o_fault;
  logic [15:0] o_period;

  modport master (
    output i_clk_div, i_rst_div,
    input  o_rise_ce, o_fall_ce, o_rst_sync,
    input  o_locked, o_fault, o_period
  );

  modport slave (
    input  i_clk_div, i_rst_div,
    output o_rise_ce, o_fall_ce, o_rst_sync,
    output o_locked, o_fault, o_period
  );
endinterface

// File: rtl/clock_edge_monitor.sv
// Samples a far-end divided clock, times rise-to-rise periods and tracks lock.
// Define CLOCK_EDGE_MONITOR_PERIOD_OUT_EN to build the o_period register.
module clock_edge_monitor #(
  parameter int par_clk_divisor = 1000,
  parameter int par_tolerance   = 2,
  parameter int par_lock_count  = 4
) (
  input logic                 i_clk_mhz,
  input logic                 i_rst_mhz,
  clock_edge_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED,
    FAULT
  } state_t;

  localparam logic signed [16:0] DIVS = 17'(par_clk_divisor);
  localparam logic signed [16:0] TOL  = 17'(par_tolerance);
  localparam logic        [16:0] TMO  = 17'(2 * par_clk_divisor);
  localparam logic        [3:0]  LOCK = 4'(par_lock_count);

  // [0],[1] synchronizer, [2] history
  logic [2:0]         div_sr;
  logic [1:0]         rdiv_sr;
  logic [1:0]         rst_out_sr;
  logic               rise_q;
  logic               fall_q;
  logic               locked_q;
  logic               fault_q;
  logic [15:0]        cnt;
  logic [15:0]        cnt_inc;
  logic [3:0]         good;
  logic [3:0]         good_inc;
  logic signed [16:0] diff;
  logic               rise;
  logic               fall;
  logic               rdiv;
  logic               in_tol;
  logic               tmo;
  state_t             state;

  assign rise     = div_sr[1] & ~div_sr[2];
  assign fall     = ~div_sr[1] & div_sr[2];
  assign rdiv     = rdiv_sr[1];
  assign cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign good_inc = good + 4'd1;
  assign diff     = $signed({1'b0, cnt}) - DIVS;
  assign in_tol   = (diff <= TOL) && (diff >= -TOL);
  assign tmo      = {1'b0, cnt_inc} > TMO;

  always_ff @(posedge i_clk_mhz or posedge i_rst_mhz) begin
    if (i_rst_mhz) begin
      div_sr  <= '0;
      rdiv_sr <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      div_sr  <= {div_sr[1:0], bus.i_clk_div};
      rdiv_sr <= {rdiv_sr[0], bus.i_rst_div};
      rise_q  <= rise;
      fall_q  <= fall;
      cnt     <= rise ? 16'd1 : cnt_inc;
    end
  end

  // Preset twin of the rst_div synchronizer: releases two cycles after i_rst_mhz
  always_ff @(posedge i_clk_mhz or posedge i_rst_mhz) begin
    if (i_rst_mhz) rst_out_sr <= 2'b11;
    else           rst_out_sr <= {rst_out_sr[0], bus.i_rst_div};
  end

  always_ff @(posedge i_clk_mhz or posedge i_rst_mhz) begin
    if (i_rst_mhz) begin
      state    <= IDLE;
      good     <= '0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else if (rdiv) begin
      state    <= IDLE;
      good     <= '0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            state <= ACQUIRE;
            good  <= '0;
          end
        end
        ACQUIRE: begin
          if (rise) begin
            if (in_tol) begin
              good <= good_inc;
              if (good_inc >= LOCK) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              good <= '0;
            end
          end else if (tmo) begin
            state   <= FAULT;
            fault_q <= 1'b1;
          end
        end
        LOCKED: begin
          if ((rise && !in_tol) || (!rise && tmo)) begin
            state    <= FAULT;
            locked_q <= 1'b0;
            fault_q  <= 1'b1;
          end
        end
        FAULT: begin
          if (rise) begin
            state <= ACQUIRE;
            good  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CLOCK_EDGE_MONITOR_PERIOD_OUT_EN
  logic [15:0] period_q;
  logic        eval;

  assign eval = rise && !rdiv &&
                (state == ACQUIRE || state == LOCKED);

  always_ff @(posedge i_clk_mhz or posedge i_rst_mhz) begin
    if (i_rst_mhz) period_q <= '0;
    else if (eval) period_q <= cnt;
  end

  assign bus.o_period = period_q;
`else
  assign bus.o_period = '0;
`endif

  assign bus.o_rise_ce  = rise_q;
  assign bus.o_fall_ce  = fall_q;
  assign bus.o_rst_sync = rst_out_sr[1];
  assign bus.o_locked   = locked_q;
  assign bus.o_fault    = fault_q;

endmodule
